cone_share_arbiter: RTL and testbench

//  Shares one instance of a synthesized 12-in/8-out combinational logic cone among

---
 rtl/cone_arb_pkg.sv | 35 +++
 rtl/cone_share_arbiter_rr_pick.sv | 20 ++
 rtl/cone_share_arbiter.sv | 114 +++++++++++
 tb/tb_cone_share_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cone_arb_pkg.sv
// Shared types and helpers for the time-multiplexed logic-cone arbiter.
// Holds the cone widths, the FSM state encoding and the round-robin search.
package cone_arb_pkg;

  localparam int unsigned CONE_IN_W  = 12;
  localparam int unsigned CONE_OUT_W = 8;
  localparam int unsigned MAX_REQ    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Returns {found, index} of the first set valid bit at or above ptr, wrapping at nreq
  function automatic logic [3:0] rr_first(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned         ptr,
                                          input int unsigned         nreq);
    logic       found;
    logic [2:0] idx;
    found = 1'b0;
    idx   = 3'd0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      int unsigned j;
      j = ptr + k;
      if (j >= nreq) j = j - nreq;
      if (!found && (k < nreq) && valid[3'(j)]) begin
        found = 1'b1;
        idx   = 3'(j);
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/cone_share_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first valid requester at or after ptr.
module rr_pick
  import cone_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] onehot,
  output logic [ID_W-1:0] idx
);

  logic [3:0] w_res;

  assign w_res  = rr_first(MAX_REQ'(valid), 32'(ptr), NREQ);
  assign idx    = ID_W'(w_res[2:0]);
  assign onehot = w_res[3] ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/cone_share_arbiter.sv
// Shares one external combinational cone among NREQ requesters, round-robin.
// Each access: accept vector, drive cone, wait SETTLE_CYC cycles, return captured result.
module cone_share_arbiter
  import cone_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned IN_W       = CONE_IN_W,
  parameter int unsigned OUT_W      = CONE_OUT_W,
  localparam int unsigned ID_W      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IN_W-1:0] req_vec,
  output logic [NREQ-1:0]      req_ready,
  output logic [IN_W-1:0]      cone_in,
  input  logic [OUT_W-1:0]     cone_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [OUT_W-1:0]     rsp_data,
  output logic                 busy
);

  localparam int unsigned CNT_W = 4;

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_id_q;
  logic [CNT_W-1:0]  r_cnt;
  logic [IN_W-1:0]   r_cone_in;
  logic [OUT_W-1:0]  r_rsp_data;
  logic [ID_W-1:0]   r_rsp_id;
  logic              r_rsp_valid;
  logic              r_busy;

  logic [NREQ-1:0]   w_onehot;
  logic [ID_W-1:0]   w_idx;
  logic [ID_W-1:0]   w_next_ptr;
  logic              w_accept;
  logic [IN_W-1:0]   w_vec [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_vec
    assign w_vec[i] = req_vec[i*IN_W +: IN_W];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid  (req_valid),
    .ptr    (r_rr_ptr),
    .onehot (w_onehot),
    .idx    (w_idx)
  );

  // Grant is offered only in IDLE and never while reset is asserted
  assign req_ready  = ((r_state == IDLE) && rst_n) ? w_onehot : '0;
  assign w_accept   = |(req_valid & req_ready);
  assign w_next_ptr = (w_idx == ID_W'(NREQ - 1)) ? '0 : w_idx + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_id_q      <= '0;
      r_cnt       <= '0;
      r_cone_in   <= '0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cone_in <= w_vec[w_idx];
            r_id_q    <= w_idx;
            r_rr_ptr  <= w_next_ptr;
            r_cnt     <= CNT_W'(SETTLE_CYC - 1);
            r_busy    <= 1'b1;
            r_state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_rsp_data  <= cone_out;
            r_rsp_id    <= r_id_q;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cone_in   = r_cone_in;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cone_share_arbiter.sv
// Directed and random bench for cone_share_arbiter with an external cone model and scoreboard.
module tb_cone_share_arbiter;

  localparam int unsigned NREQ       = 4;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned IN_W       = 12;
  localparam int unsigned OUT_W      = 8;
  localparam int unsigned ID_W       = 2;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [OUT_W-1:0] data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IN_W-1:0] req_vec;
  logic [NREQ-1:0]      req_ready;
  logic [IN_W-1:0]      cone_in;
  logic [OUT_W-1:0]     cone_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [OUT_W-1:0]     rsp_data;
  logic                 busy;

  logic [IN_W-1:0] vec [NREQ];
  exp_t            sb [$];
  int              glog [$];
  int              n_checks = 0;
  int              n_errors = 0;
  int              n_rsp    = 0;
  int              m_ptr    = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NREQ; i++) begin : g_vec
    assign req_vec[i*IN_W +: IN_W] = vec[i];
  end

  // Stand-in for the external netlist cone
  function automatic logic [OUT_W-1:0] cone_f(input logic [IN_W-1:0] x);
    return (x[7:0] ^ 8'h5A) + {x[3:0], x[11:8]};
  endfunction

  assign cone_out = cone_f(cone_in);

  cone_share_arbiter #(
    .NREQ       (NREQ),
    .SETTLE_CYC (SETTLE_CYC),
    .IN_W       (IN_W),
    .OUT_W      (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_vec   (req_vec),
    .req_ready (req_ready),
    .cone_in   (cone_in),
    .cone_out  (cone_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Negedge observer: predicts grants, pushes expectations, checks responses
  task automatic mon();
    int   g;
    exp_t e;
    if (!rst_n) return;
    if ((req_valid & req_ready) != '0) begin
      g = -1;
      for (int k = 0; k < int'(NREQ); k++) begin
        int j;
        j = (m_ptr + k) % int'(NREQ);
        if (g < 0 && req_valid[ID_W'(j)]) g = j;
      end
      chk("grant", 64'(req_ready), 64'(1) << g);
      sb.push_back({ID_W'(g), cone_f(vec[ID_W'(g)])});
      glog.push_back(g);
      m_ptr = (g + 1) % int'(NREQ);
    end
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy && !rsp_valid) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!busy && !rsp_valid) done = 1'b1;
    chk("idle_reached", 64'(done), 64'(1));
  endtask

  initial begin
    int base;
    int rsp_base;

    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) vec[i] = '0;
    #1;
    chk("reset_outs", 64'({cone_in, rsp_data, rsp_id, rsp_valid, busy, req_ready}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // Single request from requester 2
    vec[2]    = 12'hA5C;
    req_valid = 4'b0100;
    #1;
    chk("t2_ready", 64'(req_ready), 64'(4'b0100));
    step();
    req_valid = 4'b1011;
    #1;
    chk("t2_cone_in", 64'(cone_in), 64'(12'hA5C));
    chk("t2_settle", 64'({busy, rsp_valid, req_ready}), 64'({1'b1, 1'b0, 4'b0000}));
    step();
    chk("t2_rsp_early", 64'(rsp_valid), 64'(0));
    step();
    req_valid = '0;
    #1;
    chk("t2_rsp", 64'({rsp_valid, rsp_id, rsp_data, req_ready}),
        64'({1'b1, 2'd2, cone_f(12'hA5C), 4'b0000}));
    step();
    chk("t2_back_idle", 64'({busy, rsp_valid}), 64'(0));
    chk("t2_hold", 64'({cone_in, rsp_data}), 64'({12'hA5C, cone_f(12'hA5C)}));

    // Async reset in the middle of SETTLE drops the request
    vec[1]    = 12'h123;
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1111;
    #1;
    chk("t1_in_settle", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_async_reset", 64'({cone_in, rsp_data, rsp_id, rsp_valid, busy, req_ready}), 64'(0));
    sb.delete();
    m_ptr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vec[0] = 12'h0F1;
    vec[1] = 12'h1E2;
    vec[2] = 12'h2D3;
    vec[3] = 12'h3C4;
    #1;
    chk("t1_first_grant", 64'(req_ready), 64'(4'b0001));

    // All four continuously valid: grant order 0,1,2,3,0
    base = glog.size();
    repeat (20) step();
    req_valid = '0;
    wait_idle(10);
    chk("t3_ngrants", 64'(glog.size() - base), 64'(5));
    for (int i = 0; i < 5; i++) begin
      if (base + i < glog.size()) chk("t3_order", 64'(glog[base+i]), 64'(i % int'(NREQ)));
    end

    // Backpressure holds the response and blocks new grants
    rsp_ready = 1'b0;
    vec[0]    = 12'h3C3;
    req_valid = 4'b0001;
    base      = glog.size();
    #1;
    chk("t4_ready", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) break;
      step();
    end
    chk("t4_rsp_up", 64'(rsp_valid), 64'(1));
    repeat (10) begin
      step();
      chk("t4_hold", 64'({rsp_valid, rsp_id, rsp_data, req_ready}),
          64'({1'b1, 2'd0, cone_f(12'h3C3), 4'b0000}));
    end
    rsp_ready = 1'b1;
    step();
    chk("t4_release", 64'({busy, rsp_valid, req_ready}), 64'({1'b0, 1'b0, 4'b1000}));
    step();
    req_valid = '0;
    wait_idle(10);
    chk("t4_grants", 64'({glog.size() - base == 2, glog[base], glog[base+1]}),
        64'({1'b1, 32'd0, 32'd3}));

    // Pointer wrap and advance only on grant
    chk("t5_ptr0", 64'(dut.r_rr_ptr), 64'(0));
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    chk("t5_ptr_wrap", 64'(dut.r_rr_ptr), 64'(0));
    wait_idle(10);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    chk("t5_ptr2", 64'(dut.r_rr_ptr), 64'(2));
    wait_idle(10);
    base      = glog.size();
    req_valid = 4'b1111;
    step();
    req_valid = '0;
    chk("t5_next_grant", 64'(glog.size() > base ? glog[base] : -1), 64'(2));
    wait_idle(10);

    // Random traffic with random backpressure and changing vectors
    rsp_base = n_rsp;
    for (int c = 0; c < 20000 && (n_rsp - rsp_base) < 1000; c++) begin
      for (int i = 0; i < int'(NREQ); i++) vec[i] = 12'($urandom());
      req_valid = 4'($urandom());
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(20);
    chk("t6_rsp_count", 64'((n_rsp - rsp_base) >= 1000), 64'(1));
    chk("t6_sb_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
